// File: rtl/branch_queue_pkg.sv
// Shared widths and the queue entry payload for the branch queue slice.
package branch_queue_pkg;

  localparam int unsigned GH_WIDTH         = 8;
  localparam int unsigned PATTERN_WIDTH    = GH_WIDTH;
  localparam int unsigned INST_MEM_WIDTH   = 16;
  localparam int unsigned BQ_WIDTH_DEFAULT = 3;

  typedef struct packed {
    logic [PATTERN_WIDTH-1:0]  pattern;
    logic [1:0]                prediction;
    logic [INST_MEM_WIDTH-1:0] taken_addr;
    logic [INST_MEM_WIDTH-1:0] fall_addr;
  } bq_entry_t;

endpackage

// File: rtl/branch_queue_bq_fifo.sv
// Circular pointer/count FIFO of bq_entry_t with synchronous clear and
// combinational head read.
module bq_fifo
  import branch_queue_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = BQ_WIDTH_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  bq_entry_t wdata,
  output bq_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  (* ram_style = "distributed" *) bq_entry_t mem [DEPTH];

  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [CW-1:0]         count;

  // Pointers wrap naturally at DEPTH; clear squashes every entry at once.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + DEPTH_LOG2'(1);
      if (pop)  head <= head + DEPTH_LOG2'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wdata;
  end

  assign rdata = mem[head];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_queue.sv
// In-flight conditional branch tracker: compares resolved direction with the
// fetch-time prediction and drives PHT update and fetch redirect.
// Optional macro BQ_STATS_EN adds saturating branch/miss counters.
module branch_queue
  import branch_queue_pkg::*;
#(
  parameter int unsigned BQ_WIDTH = BQ_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enq_valid,
  input  logic [PATTERN_WIDTH-1:0]  enq_pattern,
  input  logic [1:0]                enq_prediction,
  input  logic [INST_MEM_WIDTH-1:0] enq_taken_addr,
  input  logic [INST_MEM_WIDTH-1:0] enq_fall_addr,
  input  logic                      res_valid,
  input  logic                      res_taken,
  output logic                      full,
  output logic                      empty,
  output logic                      commit_b,
  output logic                      failure,
  output logic [PATTERN_WIDTH-1:0]  pattern_end,
  output logic [1:0]                prediction_end,
  output logic                      flush,
  output logic [INST_MEM_WIDTH-1:0] addr_on_failure
`ifdef BQ_STATS_EN
  ,
  output logic [31:0]               stat_branches,
  output logic [31:0]               stat_misses
`endif
);

  bq_entry_t head_entry;
  bq_entry_t enq_entry;
  logic      res_fire_c;
  logic      mispredict_now_c;
  logic      enq_fire_c;
  logic      pop_c;

  assign enq_entry = '{pattern:    enq_pattern,
                       prediction: enq_prediction,
                       taken_addr: enq_taken_addr,
                       fall_addr:  enq_fall_addr};

  // A resolve frees the head slot in the same edge, so full only blocks a
  // push when no correct resolve accompanies it.
  always_comb begin
    res_fire_c       = 1'b0;
    mispredict_now_c = 1'b0;
    enq_fire_c       = 1'b0;
    pop_c            = 1'b0;
    res_fire_c       = res_valid && !empty && !flush;
    mispredict_now_c = res_fire_c && (head_entry.prediction[1] != res_taken);
    pop_c            = res_fire_c && !mispredict_now_c;
    enq_fire_c       = enq_valid && !flush && !mispredict_now_c && (!full || pop_c);
  end

  bq_fifo #(
    .DEPTH_LOG2 (BQ_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq_fire_c),
    .pop   (pop_c),
    .clear (mispredict_now_c),
    .wdata (enq_entry),
    .rdata (head_entry),
    .full  (full),
    .empty (empty)
  );

  // Pulses clear every non-resolve cycle; payload registers hold their value.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_b        <= 1'b0;
      failure         <= 1'b0;
      flush           <= 1'b0;
      pattern_end     <= '0;
      prediction_end  <= '0;
      addr_on_failure <= '0;
    end else begin
      commit_b <= res_fire_c;
      failure  <= mispredict_now_c;
      flush    <= mispredict_now_c;
      if (res_fire_c) begin
        pattern_end     <= head_entry.pattern;
        prediction_end  <= head_entry.prediction;
        addr_on_failure <= res_taken ? head_entry.taken_addr : head_entry.fall_addr;
      end
    end
  end

`ifdef BQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches <= '0;
      stat_misses   <= '0;
    end else begin
      if (res_fire_c && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mispredict_now_c && (stat_misses != 32'hFFFF_FFFF))
        stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_queue.sv
// Directed bench for branch_queue; hand-computed expectations per step.
module tb_branch_queue;
  import branch_queue_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      enq_valid;
  logic [PATTERN_WIDTH-1:0]  enq_pattern;
  logic [1:0]                enq_prediction;
  logic [INST_MEM_WIDTH-1:0] enq_taken_addr;
  logic [INST_MEM_WIDTH-1:0] enq_fall_addr;
  logic                      res_valid;
  logic                      res_taken;
  logic                      full;
  logic                      empty;
  logic                      commit_b;
  logic                      failure;
  logic [PATTERN_WIDTH-1:0]  pattern_end;
  logic [1:0]                prediction_end;
  logic                      flush;
  logic [INST_MEM_WIDTH-1:0] addr_on_failure;
`ifdef BQ_STATS_EN
  logic [31:0]               stat_branches;
  logic [31:0]               stat_misses;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_queue dut (
    .clk             (clk),
    .reset           (reset),
    .enq_valid       (enq_valid),
    .enq_pattern     (enq_pattern),
    .enq_prediction  (enq_prediction),
    .enq_taken_addr  (enq_taken_addr),
    .enq_fall_addr   (enq_fall_addr),
    .res_valid       (res_valid),
    .res_taken       (res_taken),
    .full            (full),
    .empty           (empty),
    .commit_b        (commit_b),
    .failure         (failure),
    .pattern_end     (pattern_end),
    .prediction_end  (prediction_end),
    .flush           (flush),
    .addr_on_failure (addr_on_failure)
`ifdef BQ_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_misses     (stat_misses)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later, idle inputs.
  task automatic tick(input logic ev, input logic [7:0] pat, input logic [1:0] pr,
                      input logic [15:0] ta, input logic [15:0] fa,
                      input logic rv, input logic rt);
    enq_valid      = ev;
    enq_pattern    = PATTERN_WIDTH'(pat);
    enq_prediction = pr;
    enq_taken_addr = INST_MEM_WIDTH'(ta);
    enq_fall_addr  = INST_MEM_WIDTH'(fa);
    res_valid      = rv;
    res_taken      = rt;
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    res_valid = 1'b0;
    res_taken = 1'b0;
  endtask

  task automatic enq(input logic [7:0] pat, input logic [1:0] pr,
                     input logic [15:0] ta, input logic [15:0] fa);
    tick(1'b1, pat, pr, ta, fa, 1'b0, 1'b0);
  endtask

  task automatic res(input logic rt);
    tick(1'b0, 8'h00, 2'b00, 16'h0, 16'h0, 1'b1, rt);
  endtask

  task automatic chk_commit(input string tag, input logic fail, input logic [7:0] pat,
                            input logic [1:0] pr, input logic [15:0] addr);
    chk({tag, ".commit_b"},  32'(commit_b), 32'd1);
    chk({tag, ".failure"},   32'(failure), 32'(fail));
    chk({tag, ".flush"},     32'(flush), 32'(fail));
    chk({tag, ".pattern"},   32'(pattern_end), 32'(pat));
    chk({tag, ".pred"},      32'(prediction_end), 32'(pr));
    chk({tag, ".addr"},      32'(addr_on_failure), 32'(addr));
  endtask

  initial begin
    reset = 1'b1;
    enq_valid = 1'b0; enq_pattern = '0; enq_prediction = '0;
    enq_taken_addr = '0; enq_fall_addr = '0; res_valid = 1'b0; res_taken = 1'b0;
    tick(1'b0, 8'h00, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rst.empty",    32'(empty), 32'd1);
    chk("rst.full",     32'(full), 32'd0);
    chk("rst.commit_b", 32'(commit_b), 32'd0);
    chk("rst.flush",    32'(flush), 32'd0);
    chk("rst.pattern",  32'(pattern_end), 32'd0);
    chk("rst.addr",     32'(addr_on_failure), 32'd0);
    reset = 1'b0;

    // Correct predictions, FIFO order
    enq(8'h11, 2'b10, 16'h0100, 16'h0101);
    enq(8'h22, 2'b01, 16'h0200, 16'h0201);
    enq(8'h33, 2'b11, 16'h0300, 16'h0301);
    chk("ok.empty0", 32'(empty), 32'd0);
    res(1'b1); chk_commit("ok.a", 1'b0, 8'h11, 2'b10, 16'h0100);
    res(1'b0); chk_commit("ok.b", 1'b0, 8'h22, 2'b01, 16'h0201);
    res(1'b1); chk_commit("ok.c", 1'b0, 8'h33, 2'b11, 16'h0300);
    chk("ok.empty1", 32'(empty), 32'd1);
    tick(1'b0, 8'h00, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("idle.commit_b", 32'(commit_b), 32'd0);
    chk("idle.hold_pat", 32'(pattern_end), 32'h33);

    // Mispredict squashes B; flush-cycle enq/res ignored; stray resolve ignored
    enq(8'h44, 2'b11, 16'h0104, 16'h0105);
    enq(8'h55, 2'b10, 16'h0204, 16'h0205);
    res(1'b0); chk_commit("mis.a", 1'b1, 8'h44, 2'b11, 16'h0105);
    chk("mis.empty", 32'(empty), 32'd1);
    tick(1'b1, 8'h66, 2'b11, 16'h0600, 16'h0601, 1'b1, 1'b1);
    chk("flc.commit_b", 32'(commit_b), 32'd0);
    chk("flc.flush",    32'(flush), 32'd0);
    chk("flc.empty",    32'(empty), 32'd1);
    res(1'b1);
    chk("stray.commit_b", 32'(commit_b), 32'd0);
    chk("stray.pattern",  32'(pattern_end), 32'h44);

    // Full, dropped 9th enqueue, enq+resolve while full, drain across wrap
    for (int i = 0; i < 8; i++) enq(8'h80 + 8'(i), 2'b10, 16'h0300 + 16'(i), 16'h0700);
    chk("full.full", 32'(full), 32'd1);
    enq(8'hEE, 2'b00, 16'h0EEE, 16'h0EEF);
    chk("full.drop", 32'(full), 32'd1);
    tick(1'b1, 8'h88, 2'b10, 16'h0308, 16'h0700, 1'b1, 1'b1);
    chk_commit("full.sim", 1'b0, 8'h80, 2'b10, 16'h0300);
    chk("full.still", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      res(1'b1);
      chk_commit($sformatf("drain%0d", i), 1'b0, 8'h80 + 8'(i), 2'b10, 16'h0300 + 16'(i));
    end
    chk("drain.empty", 32'(empty), 32'd1);

    // Mispredict with concurrent enqueue
    enq(8'h90, 2'b00, 16'h0400, 16'h0401);
    tick(1'b1, 8'h91, 2'b11, 16'h0500, 16'h0501, 1'b1, 1'b1);
    chk_commit("mcq", 1'b1, 8'h90, 2'b00, 16'h0400);
    chk("mcq.empty", 32'(empty), 32'd1);
    tick(1'b0, 8'h00, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("mcq.empty2", 32'(empty), 32'd1);
    res(1'b1);
    chk("mcq.absent", 32'(commit_b), 32'd0);

    // Reset mid-queue wins over simultaneous enqueue/resolve
    for (int i = 0; i < 5; i++) enq(8'hA0 + 8'(i), 2'b10, 16'h0800, 16'h0801);
    reset = 1'b1;
    tick(1'b1, 8'hAF, 2'b00, 16'h0900, 16'h0901, 1'b1, 1'b0);
    reset = 1'b0;
    chk("mrst.empty",    32'(empty), 32'd1);
    chk("mrst.commit_b", 32'(commit_b), 32'd0);
    chk("mrst.flush",    32'(flush), 32'd0);
    chk("mrst.pattern",  32'(pattern_end), 32'd0);

    // Four resolves, last one a miss
    for (int i = 0; i < 4; i++) enq(8'hB0 + 8'(i), 2'b10, 16'h0A00 + 16'(i), 16'h0B00 + 16'(i));
    res(1'b1); chk_commit("st.0", 1'b0, 8'hB0, 2'b10, 16'h0A00);
    res(1'b1); chk_commit("st.1", 1'b0, 8'hB1, 2'b10, 16'h0A01);
    res(1'b1); chk_commit("st.2", 1'b0, 8'hB2, 2'b10, 16'h0A02);
    res(1'b0); chk_commit("st.3", 1'b1, 8'hB3, 2'b10, 16'h0B03);
`ifdef BQ_STATS_EN
    chk("stat.branches", stat_branches, 32'd4);
    chk("stat.misses",   stat_misses, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_queue.md
Name: branch_queue

Overview:
- Tracks in-flight conditional branches between fetch and branch resolution.
- At decode, each branch is enqueued with the PHT index and 2-bit prediction captured at fetch, plus both candidate next-PCs.
- When the branch resolves, in program order, the block compares the actual direction with the prediction.
- It then drives the PHT/GH update (`commit_b`, `pattern_end`, `prediction_end`, `failure`) and the fetch redirect (`flush`, `addr_on_failure`).
- The `flush` output drives fetch's reset input.

Parameters:
- BQ_WIDTH, 3, log2 of queue depth (depth = 8 entries).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enq_valid  in  1  decode dispatches a conditional branch this cycle
- enq_pattern  in  PATTERN_WIDTH  PHT index captured at fetch
- enq_prediction  in  2  PHT counter captured at fetch
- enq_taken_addr  in  INST_MEM_WIDTH  branch target (c_j)
- enq_fall_addr  in  INST_MEM_WIDTH  branch PC + 1
- res_valid  in  1  oldest outstanding branch resolved this cycle
- res_taken  in  1  actual direction of that branch
- full  out  1  queue holds 2**BQ_WIDTH entries; decode must stall
- empty  out  1  queue holds 0 entries
- commit_b  out  1  one-cycle pulse: PHT/GH update valid
- failure  out  1  resolved branch was mispredicted (qualified by commit_b)
- pattern_end  out  PATTERN_WIDTH  PHT index to update
- prediction_end  out  2  counter value captured at fetch for that branch
- flush  out  1  one-cycle redirect pulse to fetch and decode
- addr_on_failure  out  INST_MEM_WIDTH  correct next PC on misprediction

Behaviour:
- **Storage:** circular buffer of 2**BQ_WIDTH entries {pattern, prediction, taken_addr, fall_addr}.
  - head and tail pointers are BQ_WIDTH bits and wrap modulo depth.
  - count is BQ_WIDTH+1 bits.
  - full = (count == 2**BQ_WIDTH); empty = (count == 0); both combinational from count.
- **Reset:** head = tail = count = 0. commit_b, failure, flush = 0. pattern_end, prediction_end, addr_on_failure = 0.
- **Enqueue:** on a clock edge with enq_valid && !full && !flush && !mispredict_now:
  - the entry is written at tail and tail increments.
  - An enqueue while full is dropped; a bench flags it as a protocol error.
- **Resolve:** on a clock edge with res_valid && !empty:
  - mispredict_now = head.prediction[1] != res_taken (combinational).
  - Registered outputs, valid the next cycle:
    - commit_b = 1, failure = mispredict_now
    - pattern_end = head.pattern, prediction_end = head.prediction
    - flush = mispredict_now
    - addr_on_failure = res_taken ? head.taken_addr : head.fall_addr
  - Correct prediction: head increments.
  - Misprediction: the whole queue is cleared (head = tail = count = 0); all younger entries are wrong-path. A same-cycle enqueue is dropped.
- **Latency:** one cycle from res_valid to commit_b/flush.
- **Idle cycles:** commit_b, failure and flush deassert in every cycle that is not a registered resolve. addr_on_failure, pattern_end and prediction_end hold their last value.
- **Resolve while empty:** ignored; no outputs pulse.
- **Simultaneous enqueue and correct resolve:** count unchanged; legal even when full, because the resolve frees the slot in the same edge. full is therefore not a blocker when res_valid && !mispredict_now.
- **Cycle with flush high:** enq_valid is ignored, because decode holds wrong-path instructions. res_valid is ignored as well; resolution is in order and everything was squashed.
- **Wrap-around:** pointers roll from 2**BQ_WIDTH-1 to 0 with no bubble.
- **Reset priority:** reset overrides everything in the same edge.
- **Update arithmetic:** fetch computes the counter update from prediction_end and failure. This block never modifies the counter.

Optional Feature:
- Macro: BQ_STATS_EN.
- **Defined:** adds outputs stat_branches [31:0] and stat_misses [31:0].
  - Both are 0 on reset.
  - stat_branches increments on every registered resolve (commit_b pulse).
  - stat_misses increments when failure also = 1.
  - Both saturate at 32'hFFFF_FFFF.
- **Undefined:** the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- common.vh holds PATTERN_WIDTH, INST_MEM_WIDTH and GH_WIDTH.
- common.vh also gains BQ_WIDTH and a packed typedef bq_entry_t {pattern, prediction, taken_addr, fall_addr}.
- Sub-module bq_fifo: pointer/count FIFO of bq_entry_t with a synchronous clear input, (* ram_style = "distributed" *) storage and combinational head read. branch_queue adds compare, output registers and stats.

Test Plan:
- **Correct predictions:** enqueue 3 branches (prediction 2'b10, 2'b01, 2'b11); resolve taken, not-taken, taken -> three commit_b pulses with failure=0, pattern_end matching the enqueue order, empty=1 after the last.
- **Mispredict and squash:** enqueue A (pred 2'b11, fall 0x105) then B; resolve A not-taken -> next cycle commit_b=1, failure=1, flush=1, addr_on_failure=0x105; queue empty; B never commits.
- **Full and wrap-around:** fill 8 entries -> full=1; a 9th enq is dropped. Enq plus correct resolve on the same cycle keeps count=8. Drain 8 -> outputs in FIFO order across the pointer wrap.
- **Mispredict with concurrent enqueue:** resolve mispredict with enq_valid=1 -> the enqueued entry is absent, and count=0 after flush.
- **Flush cycle and stray resolve:** enq_valid and res_valid asserted during the flush cycle are ignored. A resolve on an empty queue gives no commit_b pulse.
- **Reset and stats:** reset asserted mid-queue (5 entries) -> next cycle empty=1 and all pulses 0. With BQ_STATS_EN, 4 resolves with 1 miss -> stat_branches=4, stat_misses=1.
